pio_input_edge_irq: RTL and testbench
=====================================

// Module: pio_input_edge_irq
// PURPOSE
//  Avalon-MM slave input PIO for the board push-buttons and switches; the input-side counterpart of the LED output PIO.
//  - Synchronises and debounces WIDTH external inputs.
//  - Latches per-bit edge events and raises a maskable interrupt to the Nios II.
//  - Sits on the Qsys data master next to the LED PIO, same 2-bit address / 32-bit data slave profile.
// PARAMETERS
//  WIDTH            8      number of input bits (1..32)
//  DEBOUNCE_CYCLES  50000  clk cycles per debounce sample tick (>=1; 50000 = 1 ms at 50 MHz)
//  EDGE_MODE        0      edge captured: 0 rising, 1 falling, 2 any
// PORTS
//  clk         in   1      system clock
//  reset_n     in   1      asynchronous, active-low reset
//  address     in   2      register select
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe
//  writedata   in   32     write data; bits [WIDTH-1:0] used
//  read_n      in   1      active-low read strobe (unused internally; readdata is always driven)
//  in_port     in   WIDTH  raw asynchronous button/switch inputs
//  readdata    out  32     registered read data, bits above WIDTH read 0
//  irq         out  1      level interrupt, active high
// BEHAVIOUR
//  Reset
//   - reset_n low clears every register asynchronously to 0: sync1, sync2, s0, s1, deb, deb_prev, prescaler, mask, edge_cap, readdata.
//   - irq is 0 while in reset and 0 immediately after.
//  Synchroniser
//   - sync1 <= in_port; sync2 <= sync1 (2-flop).
//   - Nothing downstream samples in_port directly.
//  Prescaler
//   - cnt counts 0..DEBOUNCE_CYCLES-1 and wraps to 0.
//   - tick = (cnt == DEBOUNCE_CYCLES-1); DEBOUNCE_CYCLES=1 gives a tick every cycle.
//  Debounce, per bit, on tick only
//   - if sync2 == s0 == s1 (pre-update values), then deb <= sync2.
//   - then s0 <= sync2 and s1 <= s0.
//   - So a level must hold across 3 consecutive ticks.
//   - Any disagreement leaves deb unchanged.
//   - Latency from a stable in_port change to deb: <= 3*DEBOUNCE_CYCLES + 3 cycles.
//  Edge detect
//   - deb_prev <= deb every cycle.
//   - edge = deb & ~deb_prev (mode 0), ~deb & deb_prev (mode 1), deb ^ deb_prev (mode 2).
//   - edge_cap[i] <= 1 on edge[i]; it is visible on the cycle after deb changes.
//  Register map (write = chipselect & ~write_n)
//   - 0 DATA: RO, deb. Writes ignored.
//   - 1 MASK: RW, mask <= writedata[WIDTH-1:0].
//   - 2 EDGE: RW1C, write clears edge_cap bits where writedata[i]=1.
//     A new edge on the same cycle as the clear wins: the bit stays 1.
//   - 3 RAW: RO, sync2 (synchronised, not debounced). Writes ignored.
//  Read timing
//   - readdata <= zero-extended mux(address) every clk, independent of chipselect.
//   - Read latency is 1 cycle; the Qsys slave is declared readLatency=1, no waitrequest.
//  Interrupt
//   - irq = |(edge_cap & mask), combinational from registers only.
//   - irq stays high until the bit is cleared or masked; masking does not clear edge_cap.
//  Power-up
//   - An input held at 1 through reset debounces to 1 after 3 ticks.
//   - In modes 0 and 2 that sets edge_cap; firmware clears EDGE before enabling MASK.
//  Reset mid-operation
//   - Aborts any debounce in progress and drops irq at once.
//   - No edge is recorded for the reset itself.
// TESTING (WIDTH=8, DEBOUNCE_CYCLES=4, EDGE_MODE=0 unless noted)
//  1 Reset: hold reset_n low with in_port=0x00 -> readdata=0, irq=0; after release, addresses 0..3 all read 0x00000000.
//  2 in_port 0x00->0x01 held -> DATA reads 0x01 within 15 cycles; EDGE reads 0x01; irq=0; write MASK=0x01 -> irq=1 on next cycle.
//  3 Bounce: toggle in_port[1] every 3 cycles for 60 cycles, then hold 0 -> DATA bit1 never 1, EDGE=0x00, irq stays 0.
//  4 W1C: with EDGE=0x03 and MASK=0x03, write 0x01 to addr 2 -> EDGE=0x02, irq=1; write 0x02 -> EDGE=0x00, irq=0.
//    Repeat the clear coincident with a new bit0 edge -> bit0 remains 1.
//  5 EDGE_MODE=2: in_port[7] 0->1, clear, 1->0 -> EDGE bit7 sets on both transitions; EDGE_MODE=1 sets only on the fall.
//  6 Reset mid-operation: EDGE=0xFF, MASK=0xFF, irq=1; pulse reset_n low between clk edges -> irq=0 immediately, MASK=0x00.
//    A back-to-back read of addr 3 then addr 0 returns RAW then DATA on consecutive cycles (latency 1).

Source files
------------

// File: rtl/pio_input_edge_irq.sv
// Avalon-MM input PIO: synchronises and debounces board inputs, latches per-bit
// edge events and raises a maskable level interrupt.
module pio_input_edge_irq #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned EDGE_MODE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic             read_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_MASK = 2'd1,
        ADDR_EDGE = 2'd2,
        ADDR_RAW  = 2'd3
    } reg_addr_t;

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_s0;
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_deb;
    logic [WIDTH-1:0] r_deb_prev;
    logic [CW-1:0]    r_prescaler;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edge_cap;

    logic             w_tick;
    logic             w_write;
    logic [WIDTH-1:0] w_agree;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rd_mux;
    logic             w_unused;

    // read_n is not needed: readdata is refreshed every cycle.
    assign w_unused = ^{read_n, writedata};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

    // With DEBOUNCE_CYCLES=1 the counter is pinned at 0 and ticks every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prescaler <= '0;
        end else if (r_prescaler == CNT_MAX) begin
            r_prescaler <= '0;
        end else begin
            r_prescaler <= r_prescaler + CW'(1);
        end
    end

    assign w_tick  = (r_prescaler == CNT_MAX);
    assign w_agree = ~(r_sync2 ^ r_s0) & ~(r_s0 ^ r_s1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s0  <= '0;
            r_s1  <= '0;
            r_deb <= '0;
        end else if (w_tick) begin
            r_deb <= (r_deb & ~w_agree) | (r_sync2 & w_agree);
            r_s0  <= r_sync2;
            r_s1  <= r_s0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_deb_prev <= '0;
        end else begin
            r_deb_prev <= r_deb;
        end
    end

    always_comb begin
        w_edge = '0;
        case (EDGE_MODE)
            0:       w_edge = r_deb & ~r_deb_prev;
            1:       w_edge = ~r_deb & r_deb_prev;
            default: w_edge = r_deb ^ r_deb_prev;
        endcase
    end

    assign w_write = chipselect & ~write_n;
    assign w_clr   = (w_write && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= '0;
        end else if (w_write && (address == ADDR_MASK)) begin
            r_mask <= writedata[WIDTH-1:0];
        end
    end

    // Set is ORed in after the clear so a coincident new edge survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_cap <= '0;
        end else begin
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge;
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (reg_addr_t'(address))
            ADDR_DATA: w_rd_mux[WIDTH-1:0] = r_deb;
            ADDR_MASK: w_rd_mux[WIDTH-1:0] = r_mask;
            ADDR_EDGE: w_rd_mux[WIDTH-1:0] = r_edge_cap;
            ADDR_RAW:  w_rd_mux[WIDTH-1:0] = r_sync2;
            default:   w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= w_rd_mux;
        end
    end

    assign irq = |(r_edge_cap & r_mask);

endmodule

// File: tb/tb_pio_input_edge_irq.sv
// Directed self-checking bench for pio_input_edge_irq; one instance per edge mode
// shares the bus and inputs, WIDTH=8 and DEBOUNCE_CYCLES=4.
module tb_pio_input_edge_irq;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic        read_n;
    logic [7:0]  in_port;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc;

    pio_input_edge_irq #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .read_n(read_n), .in_port(in_port),
        .readdata(rd0), .irq(irq0));

    pio_input_edge_irq #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .read_n(read_n), .in_port(in_port),
        .readdata(rd1), .irq(irq1));

    pio_input_edge_irq #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .read_n(read_n), .in_port(in_port),
        .readdata(rd2), .irq(irq2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; a debounce tick falls on every edge where cyc%4==0.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a);
        @(negedge clk);
        address = a;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        in_port = 8'h00;
        wait_cycles(3);
        n_checks++;
        if (rd0 !== 32'h0) begin n_fail++; $display("FAIL reset_readdata: got %h expected %h", rd0, 32'h0); end
        n_checks++;
        if (irq0 !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq0); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (irq0 !== 1'b0) begin n_fail++; $display("FAIL post_reset_irq: got %b expected 0", irq0); end
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_write(2'd3, 32'hFFFF_FFFF);
        for (int unsigned a = 0; a < 4; a++) begin
            bus_read(2'(a));
            n_checks++;
            if (rd0 !== 32'h0) begin n_fail++; $display("FAIL reset_addr%0d: got %h expected %h", a, rd0, 32'h0); end
        end
    endtask

    task automatic test_debounce;
        int n;
        bit found;
        n = 0;
        found = 0;
        @(negedge clk);
        address = 2'd0;
        in_port = 8'h01;
        while (!found && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (rd0 === 32'h1) found = 1;
        end
        n_checks++;
        if (!found || n > 15) begin n_fail++; $display("FAIL data_latency: got %0d cycles (seen=%0d) expected <= 15", n, found); end
        bus_read(2'd2);
        n_checks++;
        if (rd0 !== 32'h1) begin n_fail++; $display("FAIL edge_after_rise: got %h expected %h", rd0, 32'h1); end
        n_checks++;
        if (irq0 !== 1'b0) begin n_fail++; $display("FAIL irq_unmasked: got %b expected 0", irq0); end
        bus_write(2'd1, 32'h1);
        n_checks++;
        if (irq0 !== 1'b1) begin n_fail++; $display("FAIL irq_after_mask: got %b expected 1", irq0); end
    endtask

    task automatic test_bounce;
        bus_write(2'd2, 32'h1);
        n_checks++;
        if (irq0 !== 1'b0) begin n_fail++; $display("FAIL irq_after_clear: got %b expected 0", irq0); end
        @(negedge clk);
        address = 2'd0;
        for (int i = 0; i < 20; i++) begin
            in_port[1] = ~in_port[1];
            repeat (3) begin
                @(posedge clk);
                #1;
                n_checks++;
                if (rd0[1] !== 1'b0) begin n_fail++; $display("FAIL bounce_data_bit1: got %b expected 0", rd0[1]); end
                n_checks++;
                if (irq0 !== 1'b0) begin n_fail++; $display("FAIL bounce_irq: got %b expected 0", irq0); end
            end
        end
        wait_cycles(24);
        bus_read(2'd0);
        n_checks++;
        if (rd0 !== 32'h1) begin n_fail++; $display("FAIL bounce_data: got %h expected %h", rd0, 32'h1); end
        bus_read(2'd2);
        n_checks++;
        if (rd0 !== 32'h0) begin n_fail++; $display("FAIL bounce_edge: got %h expected %h", rd0, 32'h0); end
        n_checks++;
        if (irq0 !== 1'b0) begin n_fail++; $display("FAIL bounce_irq_end: got %b expected 0", irq0); end
    endtask

    task automatic test_w1c;
        int unsigned e, t1, t;
        in_port = 8'h00;
        wait_cycles(20);
        bus_write(2'd2, 32'hFF);
        in_port = 8'h03;
        wait_cycles(20);
        bus_read(2'd2);
        n_checks++;
        if (rd0 !== 32'h3) begin n_fail++; $display("FAIL w1c_setup_edge: got %h expected %h", rd0, 32'h3); end
        bus_write(2'd1, 32'h3);
        bus_write(2'd2, 32'h1);
        bus_read(2'd2);
        n_checks++;
        if (rd0 !== 32'h2) begin n_fail++; $display("FAIL w1c_clear_bit0: got %h expected %h", rd0, 32'h2); end
        n_checks++;
        if (irq0 !== 1'b1) begin n_fail++; $display("FAIL w1c_irq_bit1: got %b expected 1", irq0); end
        bus_write(2'd2, 32'h2);
        bus_read(2'd2);
        n_checks++;
        if (rd0 !== 32'h0) begin n_fail++; $display("FAIL w1c_clear_bit1: got %h expected %h", rd0, 32'h0); end
        n_checks++;
        if (irq0 !== 1'b0) begin n_fail++; $display("FAIL w1c_irq_clear: got %b expected 0", irq0); end

        // Drop bit0, then raise it so the debounced edge lands on the clear write.
        in_port = 8'h02;
        wait_cycles(20);
        @(negedge clk);
        e = cyc;
        in_port = 8'h03;
        t1 = ((e + 6) / 4) * 4;
        t  = t1 + 8;
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (irq0 !== 1'b0) begin n_fail++; $display("FAIL coincide_pre_irq: got %b expected 0", irq0); end
        bus_write(2'd2, 32'h1);
        n_checks++;
        if (irq0 !== 1'b1) begin n_fail++; $display("FAIL coincide_irq: got %b expected 1", irq0); end
        bus_read(2'd2);
        n_checks++;
        if (rd0 !== 32'h1) begin n_fail++; $display("FAIL coincide_edge: got %h expected %h", rd0, 32'h1); end
    endtask

    task automatic test_edge_modes;
        in_port = 8'h00;
        wait_cycles(20);
        bus_write(2'd2, 32'hFF);
        in_port = 8'h80;
        wait_cycles(20);
        bus_read(2'd2);
        n_checks++;
        if (rd2 !== 32'h80) begin n_fail++; $display("FAIL mode2_rise: got %h expected %h", rd2, 32'h80); end
        n_checks++;
        if (rd1 !== 32'h00) begin n_fail++; $display("FAIL mode1_rise: got %h expected %h", rd1, 32'h00); end
        n_checks++;
        if (rd0 !== 32'h80) begin n_fail++; $display("FAIL mode0_rise: got %h expected %h", rd0, 32'h80); end
        bus_write(2'd2, 32'hFF);
        in_port = 8'h00;
        wait_cycles(20);
        bus_read(2'd2);
        n_checks++;
        if (rd2 !== 32'h80) begin n_fail++; $display("FAIL mode2_fall: got %h expected %h", rd2, 32'h80); end
        n_checks++;
        if (rd1 !== 32'h80) begin n_fail++; $display("FAIL mode1_fall: got %h expected %h", rd1, 32'h80); end
        n_checks++;
        if (rd0 !== 32'h00) begin n_fail++; $display("FAIL mode0_fall: got %h expected %h", rd0, 32'h00); end
    endtask

    task automatic test_reset_mid;
        in_port = 8'hFF;
        wait_cycles(20);
        bus_write(2'd1, 32'hFF);
        bus_read(2'd2);
        n_checks++;
        if (rd0 !== 32'hFF) begin n_fail++; $display("FAIL mid_setup_edge: got %h expected %h", rd0, 32'hFF); end
        n_checks++;
        if (irq0 !== 1'b1) begin n_fail++; $display("FAIL mid_setup_irq: got %b expected 1", irq0); end
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (irq0 !== 1'b0) begin n_fail++; $display("FAIL mid_reset_irq0: got %b expected 0", irq0); end
        n_checks++;
        if (irq2 !== 1'b0) begin n_fail++; $display("FAIL mid_reset_irq2: got %b expected 0", irq2); end
        n_checks++;
        if (rd0 !== 32'h0) begin n_fail++; $display("FAIL mid_reset_readdata: got %h expected %h", rd0, 32'h0); end
        #1;
        reset_n = 1'b1;
        bus_read(2'd1);
        n_checks++;
        if (rd0 !== 32'h0) begin n_fail++; $display("FAIL mid_mask: got %h expected %h", rd0, 32'h0); end
        bus_read(2'd2);
        n_checks++;
        if (rd0 !== 32'h0) begin n_fail++; $display("FAIL mid_edge: got %h expected %h", rd0, 32'h0); end
        bus_read(2'd3);
        n_checks++;
        if (rd0 !== 32'hFF) begin n_fail++; $display("FAIL b2b_raw: got %h expected %h", rd0, 32'hFF); end
        bus_read(2'd0);
        n_checks++;
        if (rd0 !== 32'h0) begin n_fail++; $display("FAIL b2b_data: got %h expected %h", rd0, 32'h0); end
        wait_cycles(24);
        bus_read(2'd2);
        n_checks++;
        if (rd0 !== 32'hFF) begin n_fail++; $display("FAIL powerup_edge_mode0: got %h expected %h", rd0, 32'hFF); end
        n_checks++;
        if (rd1 !== 32'h00) begin n_fail++; $display("FAIL powerup_edge_mode1: got %h expected %h", rd1, 32'h00); end
        n_checks++;
        if (irq0 !== 1'b0) begin n_fail++; $display("FAIL powerup_irq_masked: got %b expected 0", irq0); end
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        read_n     = 1'b1;
        in_port    = 8'h00;
        test_reset();
        test_debounce();
        test_bounce();
        test_w1c();
        test_edge_modes();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
